// File: rtl/conv_enc_k7.sv
// Rate-1/2, K=7 convolutional encoder with per-frame zero termination (6 tail bits).
// One information bit per input handshake, one registered code pair per bit.
module conv_enc_k7 #(
  parameter int unsigned FRAME_LEN = 64,
  parameter logic [6:0]  G0        = 7'b1111001,
  parameter logic [6:0]  G1        = 7'b1011011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_pair,
  output logic       out_tail,
  output logic       out_last
);

  localparam int unsigned SR_W     = 6;
  localparam int unsigned TAIL_W   = 3;
  localparam int unsigned NUM_TAIL = 6;
  localparam int unsigned CNT_W    = $clog2(FRAME_LEN + 1);

  typedef enum logic {
    ST_DATA,
    ST_TAIL
  } state_e;

  state_e              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [TAIL_W-1:0]   tail_cnt_q, tail_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [1:0]          out_pair_q, out_pair_d;
  logic                out_tail_q, out_tail_d;
  logic                out_last_q, out_last_d;
  logic                slot_free_c;
  logic                accept_c;

  // Parity pair for input u against the current shift-register contents.
  function automatic logic [1:0] encode(input logic u, input logic [SR_W-1:0] sr);
    logic [6:0] v;
    v = {u, sr};
    return {^(v & G0), ^(v & G1)};
  endfunction

  assign slot_free_c = !out_valid_q || out_ready;
  assign in_ready    = !rst && (state_q == ST_DATA) && slot_free_c;
  assign accept_c    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    tail_cnt_d  = tail_cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_pair_d  = out_pair_q;
    out_tail_d  = out_tail_q;
    out_last_d  = out_last_q;

    case (state_q)
      ST_DATA: begin
        if (accept_c) begin
          out_valid_d = 1'b1;
          out_pair_d  = encode(in_bit, sr_q);
          out_tail_d  = 1'b0;
          out_last_d  = 1'b0;
          sr_d        = {in_bit, sr_q[SR_W-1:1]};
          if (bit_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            bit_cnt_d = '0;
            state_d   = ST_TAIL;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_TAIL: begin
        // Flush zeros so the trellis ends in state 0.
        if (slot_free_c) begin
          out_valid_d = 1'b1;
          out_pair_d  = encode(1'b0, sr_q);
          out_tail_d  = 1'b1;
          out_last_d  = 1'b0;
          sr_d        = {1'b0, sr_q[SR_W-1:1]};
          if (tail_cnt_q == TAIL_W'(NUM_TAIL - 1)) begin
            out_last_d = 1'b1;
            tail_cnt_d = '0;
            state_d    = ST_DATA;
          end else begin
            tail_cnt_d = tail_cnt_q + TAIL_W'(1);
          end
        end
      end
      default: state_d = ST_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_DATA;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      tail_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_pair_q  <= 2'b00;
      out_tail_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      out_valid_q <= out_valid_d;
      out_pair_q  <= out_pair_d;
      out_tail_q  <= out_tail_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pair  = out_pair_q;
  assign out_tail  = out_tail_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_enc_k7.sv
// Scoreboard bench for conv_enc_k7: three builds (FRAME_LEN 8, 1, 4) on one clock.
// Expected {pair, tail, last} entries are queued from tables or a tap model and popped per output handshake.
module tb_conv_enc_k7;

  localparam logic [6:0] G0_T = 7'o171;
  localparam logic [6:0] G1_T = 7'o133;
  localparam int unsigned NI  = 3;

  logic       clk;
  logic       rst;
  logic       in_valid  [NI];
  logic       in_ready  [NI];
  logic       in_bit    [NI];
  logic       out_valid [NI];
  logic       out_ready [NI];
  logic [1:0] out_pair  [NI];
  logic       out_tail  [NI];
  logic       out_last  [NI];

  logic [3:0] exp_q[$];
  int         n_checks;
  int         n_fail;

  conv_enc_k7 #(.FRAME_LEN(8)) u_dut_f8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_bit(in_bit[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_pair(out_pair[0]),
    .out_tail(out_tail[0]), .out_last(out_last[0])
  );

  conv_enc_k7 #(.FRAME_LEN(1)) u_dut_f1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_bit(in_bit[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_pair(out_pair[1]),
    .out_tail(out_tail[1]), .out_last(out_last[1])
  );

  conv_enc_k7 #(.FRAME_LEN(4)) u_dut_f4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_bit(in_bit[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_pair(out_pair[2]),
    .out_tail(out_tail[2]), .out_last(out_last[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Push a table of pairs (first pair in the upper bits); entries at index >= nd are tail pairs.
  task automatic push_tab(input logic [27:0] tab, input int n, input int nd);
    for (int i = 0; i < n; i++)
      exp_q.push_back({tab[2*(n-1-i) +: 2], 1'(i >= nd), 1'(i == n - 1)});
  endtask

  // Tap-delay model: generator bit (6-k) weights the input from k steps ago.
  task automatic push_model(input logic [15:0] bits, input int nbits, input int frames);
    logic [6:0] h;
    logic       u;
    logic       p0;
    logic       p1;
    for (int f = 0; f < frames; f++) begin
      h = '0;
      for (int i = 0; i < nbits + 6; i++) begin
        u  = (i < nbits) ? bits[nbits-1-i] : 1'b0;
        h  = {h[5:0], u};
        p0 = 1'b0;
        p1 = 1'b0;
        for (int k = 0; k < 7; k++) begin
          p0 = p0 ^ (G0_T[6-k] & h[k]);
          p1 = p1 ^ (G1_T[6-k] & h[k]);
        end
        exp_q.push_back({p0, p1, 1'(i >= nbits), 1'(i == nbits + 5)});
      end
    end
  endtask

  task automatic pop_cmp(input string tag, input int idx);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_extra"}, 8'(1), 8'(0));
    end else begin
      e = exp_q.pop_front();
      chk(tag, 8'({out_pair[idx], out_tail[idx], out_last[idx]}), 8'(e));
    end
  endtask

  // Stream total_bits bits (cycled from bits[nbits-1:0], MSB first) and drain all queued pairs.
  task automatic run(input string tag, input int idx, input logic [15:0] bits, input int nbits,
                     input int total_bits, input bit bp, input int max_cyc);
    int         sent;
    int         got;
    int         total;
    int         c;
    bit         stalled;
    logic [7:0] held;
    sent    = 0;
    got     = 0;
    c       = 0;
    stalled = 0;
    held    = '0;
    total   = exp_q.size();
    while (got < total && c < max_cyc) begin
      @(negedge clk);
      out_ready[idx] = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      in_valid[idx]  = (sent < total_bits);
      in_bit[idx]    = bits[nbits-1-(sent % nbits)];
      #1;
      if (stalled)
        chk({tag, "_hold"}, 8'({out_valid[idx], out_tail[idx], out_last[idx], out_pair[idx]}), held);
      if (out_valid[idx] && !out_ready[idx]) begin
        chk({tag, "_stall_rdy"}, 8'(in_ready[idx]), 8'(0));
        stalled = 1;
        held    = 8'({out_valid[idx], out_tail[idx], out_last[idx], out_pair[idx]});
      end else begin
        stalled = 0;
      end
      if (!bp && got > 0)
        chk({tag, "_contig"}, 8'(out_valid[idx]), 8'(1));
      if (out_valid[idx] && out_ready[idx]) begin
        pop_cmp(tag, idx);
        if (out_last[idx] && sent < total_bits)
          chk({tag, "_b2b_accept"}, 8'(in_ready[idx]), 8'(1));
        got++;
      end
      if (in_valid[idx] && in_ready[idx])
        sent++;
      c++;
    end
    if (got < total)
      chk({tag, "_timeout"}, 8'(got), 8'(total));
    exp_q.delete();
    @(negedge clk);
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b1;
    #1;
    chk({tag, "_idle"}, 8'(out_valid[idx]), 8'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b0;
      in_bit[i]    = 1'b0;
      out_ready[i] = 1'b1;
    end

    // Reset: in_ready low during reset, reset values after.
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) chk("rst_in_ready", 8'(in_ready[i]), 8'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_outs", 8'({out_valid[i], out_pair[i], out_tail[i], out_last[i]}), 8'(0));
      chk("rst_ready_after", 8'(in_ready[i]), 8'(1));
    end

    // All zeros, FRAME_LEN=8.
    push_tab(28'd0, 14, 8);
    run("zeros", 0, 16'h0000, 8, 8, 1'b0, 100);

    // Reset mid-frame after the third accepted 1.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid[0]  = 1'b1;
      in_bit[0]    = 1'b1;
      out_ready[0] = 1'b1;
      #1;
      chk("rm_in_ready", 8'(in_ready[0]), 8'(1));
      if (k == 1) chk("rm_pair1", 8'({out_valid[0], out_pair[0]}), 8'(3'b111));
      if (k == 2) chk("rm_pair2", 8'({out_valid[0], out_pair[0]}), 8'(3'b101));
    end
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    rst          = 1'b1;
    #1;
    chk("rm_pending", 8'({out_valid[0], out_pair[0]}), 8'(3'b110));
    chk("rm_rdy_in_rst", 8'(in_ready[0]), 8'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rm_outs", 8'({out_valid[0], out_pair[0], out_tail[0], out_last[0]}), 8'(0));
    chk("rm_rdy_after", 8'(in_ready[0]), 8'(1));
    out_ready[0] = 1'b1;

    // All ones, FRAME_LEN=8 (also proves the reset cleared sr and bit_cnt).
    push_tab(28'b11_01_10_01_01_00_11_11_00_10_01_10_10_11, 14, 8);
    run("ones", 0, 16'h00FF, 8, 8, 1'b0, 100);

    // Impulse, FRAME_LEN=1: in_valid held through the tail is ignored.
    push_tab(28'b11_10_11_11_00_01_11, 7, 1);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      out_ready[1] = 1'b1;
      in_bit[1]    = 1'b1;
      in_valid[1]  = (k < 7);
      #1;
      chk("imp_in_ready", 8'(in_ready[1]), (k == 0 || k >= 7) ? 8'(1) : 8'(0));
      if (k == 8) chk("imp_idle", 8'(out_valid[1]), 8'(0));
      if (out_valid[1] && out_ready[1]) pop_cmp("imp", 1);
    end
    chk("imp_count", 8'(exp_q.size()), 8'(0));
    exp_q.delete();
    in_valid[1] = 1'b0;

    // Backpressure: impulse with out_ready 1,0,0,1 repeating.
    push_tab(28'b11_10_11_11_00_01_11, 7, 1);
    run("bp", 1, 16'h0001, 1, 1, 1'b1, 100);

    // Back-to-back frames of 1011, FRAME_LEN=4.
    push_model(16'h000B, 4, 2);
    chk("b2b_qlen", 8'(exp_q.size()), 8'(20));
    run("b2b", 2, 16'h000B, 4, 8, 1'b0, 100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
